// File: rtl/neuron_step_scheduler.sv
// -----------------------------------------------------------------------------
// neuron_step_scheduler
//
// Timestep controller and local-port arbiter for a cluster of neurons that
// share one router local input. Issues a one-cycle start pulse to every neuron
// each timestep. Between pulses it round-robin-merges the neurons' spike
// packets into a one-entry output register that feeds the router. The router
// can stall that register with local_full.
//
// Optional feature macro: SCHED_SPIKE_COUNT_EN
//   When defined, per-step spike counters are built. When undefined, the
//   spike_count_o and last_step_spikes_o ports are tied to zero.
//
// Ports
//   clk                 clock, rising edge
//   reset               asynchronous, active-high, clears all state
//   enable              run timesteps while high
//   start_o             one-cycle start pulse, all bits identical
//   spike_valid_i       per-neuron packet-pending flag
//   spike_packet_i      packet i at [i*PACKET_W +: PACKET_W]
//   spike_ack_o         one-hot, packet consumed this cycle (combinational)
//   router_data_o       packet toward router local_in
//   router_write_o      write enable toward router write_en_local
//   router_full_i       router local_full backpressure
//   busy_o              scheduler not idle
//   step_count_o        number of START cycles (wraps)
//   overrun_count_o     number of steps that needed DRAIN (saturates)
//   spike_count_o       acks in current step (SCHED_SPIKE_COUNT_EN)
//   last_step_spikes_o  acks in previous step (SCHED_SPIKE_COUNT_EN)
// -----------------------------------------------------------------------------
module neuron_step_scheduler #(
    parameter int NUM_NEURONS = 4,
    parameter int PACKET_W    = 32,
    parameter int STEP_PERIOD = 30
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    output logic [NUM_NEURONS-1:0]          start_o,
    input  logic [NUM_NEURONS-1:0]          spike_valid_i,
    input  logic [NUM_NEURONS*PACKET_W-1:0] spike_packet_i,
    output logic [NUM_NEURONS-1:0]          spike_ack_o,
    output logic [PACKET_W-1:0]             router_data_o,
    output logic                            router_write_o,
    input  logic                            router_full_i,
    output logic                            busy_o,
    output logic [15:0]                     step_count_o,
    output logic [7:0]                      overrun_count_o,
    output logic [15:0]                     spike_count_o,
    output logic [15:0]                     last_step_spikes_o
);

    localparam int RR_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    // Counter must hold STEP_PERIOD: it steps once past the last value on the
    // way into DRAIN.
    localparam int CNT_W = $clog2(STEP_PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_PERIOD - 1);
    localparam logic [RR_W-1:0]  RR_LAST  = RR_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        COLLECT = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [15:0]         step_cnt_q;
    logic [7:0]          overrun_q;
    logic                overrun_inc;
    logic [RR_W-1:0]     rr_q;
    logic                out_vld_q;
    logic [PACKET_W-1:0] out_data_q;

    logic                grant_ok;
    logic                gnt_found;
    logic [RR_W-1:0]     gnt_idx;
    logic [RR_W:0]       cand;
    logic [PACKET_W-1:0] gnt_pkt;
    logic                pending;

    assign router_write_o = out_vld_q & ~router_full_i;
    assign router_data_o  = out_data_q;
    assign start_o        = {NUM_NEURONS{state_q == START}};
    assign busy_o         = (state_q != IDLE);
    assign step_count_o   = step_cnt_q;
    assign overrun_count_o = overrun_q;

    // Round-robin grant. The output slot accepts a new packet when it is empty
    // or is being drained to the router in this same cycle.
    always_comb begin
        grant_ok    = ((state_q == COLLECT) || (state_q == DRAIN)) &&
                      (!out_vld_q || router_write_o);
        gnt_found   = 1'b0;
        gnt_idx     = '0;
        cand        = '0;
        spike_ack_o = '0;
        for (int off = 0; off < NUM_NEURONS; off++) begin
            cand = {1'b0, rr_q} + (RR_W+1)'(off);
            if (cand >= (RR_W+1)'(NUM_NEURONS))
                cand = cand - (RR_W+1)'(NUM_NEURONS);
            if (grant_ok && !gnt_found && spike_valid_i[cand[RR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[RR_W-1:0];
            end
        end
        if (gnt_found)
            spike_ack_o[gnt_idx] = 1'b1;
    end

    assign gnt_pkt = spike_packet_i[gnt_idx*PACKET_W +: PACKET_W];

    // Requesters still waiting once this cycle's ack is accounted for.
    assign pending = |(spike_valid_i & ~spike_ack_o);

    always_comb begin
        state_d     = state_q;
        overrun_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable)
                    state_d = START;
            end
            START: begin
                state_d = COLLECT;
            end
            COLLECT: begin
                if (cnt_q == CNT_LAST) begin
                    if (pending) begin
                        state_d     = DRAIN;
                        overrun_inc = 1'b1;
                    end else if (enable) begin
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (!pending)
                    state_d = enable ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, period counter, step/overrun statistics, rr pointer.
    // The counter reads 0 during START so the START-to-START spacing is
    // exactly STEP_PERIOD cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            step_cnt_q <= '0;
            overrun_q  <= '0;
            rr_q       <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == START)
                cnt_q <= '0;
            else if ((state_q == START) || (state_q == COLLECT))
                cnt_q <= cnt_q + CNT_W'(1);
            if (state_q == START)
                step_cnt_q <= step_cnt_q + 16'd1;
            if (overrun_inc && (overrun_q != 8'hFF))
                overrun_q <= overrun_q + 8'd1;
            if (gnt_found)
                rr_q <= (gnt_idx == RR_LAST) ? '0 : gnt_idx + RR_W'(1);
        end
    end

    // Output stage: one-entry register toward the router local port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            if (gnt_found) begin
                out_vld_q  <= 1'b1;
                out_data_q <= gnt_pkt;
            end else if (router_write_o) begin
                out_vld_q  <= 1'b0;
            end
        end
    end

`ifdef SCHED_SPIKE_COUNT_EN
    logic [15:0] spike_cnt_q;
    logic [15:0] last_spikes_q;

    // START never grants, so clearing there cannot lose an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spike_cnt_q   <= '0;
            last_spikes_q <= '0;
        end else if (state_q == START) begin
            last_spikes_q <= spike_cnt_q;
            spike_cnt_q   <= '0;
        end else if (gnt_found && (spike_cnt_q != 16'hFFFF)) begin
            spike_cnt_q <= spike_cnt_q + 16'd1;
        end
    end

    assign spike_count_o      = spike_cnt_q;
    assign last_step_spikes_o = last_spikes_q;
`else
    assign spike_count_o      = '0;
    assign last_step_spikes_o = '0;
`endif

endmodule

// File: tb/tb_neuron_step_scheduler.sv
module tb_neuron_step_scheduler;

    localparam int N  = 4;
    localparam int PW = 32;
    localparam int SP = 30;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [N-1:0]    start_o;
    logic [N-1:0]    spike_valid_i;
    logic [N*PW-1:0] spike_packet_i;
    logic [N-1:0]    spike_ack_o;
    logic [PW-1:0]   router_data_o;
    logic            router_write_o;
    logic            router_full_i;
    logic            busy_o;
    logic [15:0]     step_count_o;
    logic [7:0]      overrun_count_o;
    logic [15:0]     spike_count_o;
    logic [15:0]     last_step_spikes_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    neuron_step_scheduler #(
        .NUM_NEURONS(N),
        .PACKET_W   (PW),
        .STEP_PERIOD(SP)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .start_o           (start_o),
        .spike_valid_i     (spike_valid_i),
        .spike_packet_i    (spike_packet_i),
        .spike_ack_o       (spike_ack_o),
        .router_data_o     (router_data_o),
        .router_write_o    (router_write_o),
        .router_full_i     (router_full_i),
        .busy_o            (busy_o),
        .step_count_o      (step_count_o),
        .overrun_count_o   (overrun_count_o),
        .spike_count_o     (spike_count_o),
        .last_step_spikes_o(last_step_spikes_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        bit found = 1'b0;
        for (int t = 0; t < 80 && !found; t++) begin
            tick();
            if (start_o !== 4'b0) found = 1'b1;
        end
        if (!found) begin
            n_checks++; n_fail++;
            $display("FAIL wait_start: got no start_o pulse in 80 cycles, want a pulse");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; spike_valid_i = '0; spike_packet_i = '0; router_full_i = 1'b0;
        tick(); tick();
        n_checks++; if (start_o !== 4'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0000", start_o); end
        n_checks++; if (spike_ack_o !== 4'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0000", spike_ack_o); end
        n_checks++; if (router_write_o !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b want 0", router_write_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        n_checks++; if (router_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", router_data_o); end
        n_checks++; if (step_count_o !== 16'h0) begin n_fail++; $display("FAIL rst_step: got %0d want 0", step_count_o); end
        n_checks++; if (overrun_count_o !== 8'h0) begin n_fail++; $display("FAIL rst_overrun: got %0d want 0", overrun_count_o); end
        reset = 1'b0;
    endtask

    task automatic test_periodic();
        int  last;
        bit  found;
        bit  wr_seen = 1'b0;
        tick();
        enable = 1'b1;
        last = cyc;
        for (int n = 1; n <= 3; n++) begin
            found = 1'b0;
            for (int t = 0; t < 40 && !found; t++) begin
                tick();
                if (router_write_o) wr_seen = 1'b1;
                if (start_o !== 4'b0) found = 1'b1;
            end
            n_checks++;
            if (!found) begin
                n_fail++; $display("FAIL period_pulse%0d: got no pulse want pulse", n);
            end else begin
                if (start_o !== 4'hF) begin n_fail++; $display("FAIL period_allbits%0d: got %b want 1111", n, start_o); end
                n_checks++;
                if ((cyc - last) !== ((n == 1) ? 1 : SP)) begin
                    n_fail++; $display("FAIL period_interval%0d: got %0d want %0d", n, cyc - last, (n == 1) ? 1 : SP);
                end
                last = cyc;
                tick();
                if (router_write_o) wr_seen = 1'b1;
                n_checks++;
                if (step_count_o !== 16'(n)) begin n_fail++; $display("FAIL period_stepcnt%0d: got %0d want %0d", n, step_count_o, n); end
            end
        end
        n_checks++; if (wr_seen !== 1'b0) begin n_fail++; $display("FAIL period_nowrite: got write=1 want 0"); end
    endtask

    task automatic test_burst();
        logic [N-1:0] exp_ack;
        wait_start();
        spike_valid_i = 4'hF;
        for (int i = 0; i < N; i++) spike_packet_i[i*PW +: PW] = 32'hA0 + 32'(i);
        #1;
        n_checks++; if (spike_ack_o !== 4'b0) begin n_fail++; $display("FAIL burst_start_noack: got %b want 0000", spike_ack_o); end
        for (int j = 0; j <= N; j++) begin
            tick();
            if (j > 0) spike_valid_i[j-1] = 1'b0;
            #1;
            exp_ack = (j < N) ? 4'(1 << j) : 4'b0;
            n_checks++;
            if (spike_ack_o !== exp_ack) begin n_fail++; $display("FAIL burst_ack%0d: got %b want %b", j, spike_ack_o, exp_ack); end
            n_checks++;
            if (router_write_o !== (j > 0)) begin n_fail++; $display("FAIL burst_write%0d: got %b want %b", j, router_write_o, (j > 0)); end
            if (j > 0) begin
                n_checks++;
                if (router_data_o !== 32'hA0 + 32'(j-1)) begin
                    n_fail++; $display("FAIL burst_data%0d: got %h want %h", j, router_data_o, 32'hA0 + 32'(j-1));
                end
            end
        end
        tick();
        n_checks++; if (router_write_o !== 1'b0) begin n_fail++; $display("FAIL burst_idle_write: got %b want 0", router_write_o); end
    endtask

    task automatic test_backpressure();
        int acks = 0;
        int writes = 0;
        router_full_i = 1'b1;
        spike_valid_i[2] = 1'b1;
        spike_packet_i[2*PW +: PW] = 32'hBEEF;
        #1;
        if (spike_ack_o === 4'b0100) acks++;
        for (int c = 0; c < 4; c++) begin
            tick();
            spike_valid_i[2] = 1'b0;
            #1;
            if (spike_ack_o !== 4'b0) acks++;
            if (router_write_o) writes++;
            n_checks++;
            if (router_data_o !== 32'hBEEF) begin n_fail++; $display("FAIL bp_hold%0d: got %h want 0000beef", c, router_data_o); end
        end
        n_checks++; if (writes !== 0) begin n_fail++; $display("FAIL bp_nowrite_full: got %0d writes want 0", writes); end
        tick();
        router_full_i = 1'b0;
        #1;
        n_checks++; if (router_write_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_write: got %b want 1", router_write_o); end
        n_checks++; if (router_data_o !== 32'hBEEF) begin n_fail++; $display("FAIL bp_release_data: got %h want 0000beef", router_data_o); end
        if (spike_ack_o !== 4'b0) acks++;
        tick();
        n_checks++; if (router_write_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", router_write_o); end
        n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL bp_ack_count: got %0d want 1", acks); end
    endtask

    task automatic test_round_robin();
        spike_packet_i[1*PW +: PW] = 32'h51;
        spike_packet_i[3*PW +: PW] = 32'h53;
        spike_valid_i = 4'b1010;
        #1;
        n_checks++; if (spike_ack_o !== 4'b1000) begin n_fail++; $display("FAIL rr_first: got %b want 1000", spike_ack_o); end
        tick();
        spike_valid_i[3] = 1'b0;
        #1;
        n_checks++; if (spike_ack_o !== 4'b0010) begin n_fail++; $display("FAIL rr_second: got %b want 0010", spike_ack_o); end
        n_checks++; if (router_data_o !== 32'h53) begin n_fail++; $display("FAIL rr_data0: got %h want 53", router_data_o); end
        tick();
        spike_valid_i[1] = 1'b0;
        #1;
        n_checks++; if (router_data_o !== 32'h51 || router_write_o !== 1'b1) begin
            n_fail++; $display("FAIL rr_data1: got %h/%b want 51/1", router_data_o, router_write_o);
        end
    endtask

    task automatic test_drain();
        wait_start();
        for (int k = 1; k <= SP - 1; k++) begin
            tick();
            if (k == 2) begin
                router_full_i = 1'b1;
                spike_valid_i[0] = 1'b1;
                spike_packet_i[0*PW +: PW] = 32'h11;
                #1;
                n_checks++; if (spike_ack_o !== 4'b0001) begin n_fail++; $display("FAIL drain_preload_ack: got %b want 0001", spike_ack_o); end
            end
            if (k == 3) spike_valid_i[0] = 1'b0;
        end
        spike_valid_i[1] = 1'b1;
        spike_packet_i[1*PW +: PW] = 32'h22;
        #1;
        n_checks++; if (spike_ack_o !== 4'b0) begin n_fail++; $display("FAIL drain_last_noack: got %b want 0000", spike_ack_o); end
        n_checks++; if (overrun_count_o !== 8'd0) begin n_fail++; $display("FAIL drain_overrun_pre: got %0d want 0", overrun_count_o); end
        tick();
        n_checks++; if (overrun_count_o !== 8'd1) begin n_fail++; $display("FAIL drain_overrun: got %0d want 1", overrun_count_o); end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL drain_busy: got %b want 1", busy_o); end
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (start_o !== 4'b0) begin n_fail++; $display("FAIL drain_nostart%0d: got %b want 0000", c, start_o); end
            if (c < 3) tick();
        end
        router_full_i = 1'b0;
        #1;
        n_checks++; if (spike_ack_o !== 4'b0010) begin n_fail++; $display("FAIL drain_ack: got %b want 0010", spike_ack_o); end
        n_checks++; if (router_write_o !== 1'b1 || router_data_o !== 32'h11) begin
            n_fail++; $display("FAIL drain_write0: got %b/%h want 1/11", router_write_o, router_data_o);
        end
        tick();
        spike_valid_i[1] = 1'b0;
        #1;
        n_checks++; if (start_o !== 4'hF) begin n_fail++; $display("FAIL drain_restart: got %b want 1111", start_o); end
        n_checks++; if (router_write_o !== 1'b1 || router_data_o !== 32'h22) begin
            n_fail++; $display("FAIL drain_write1: got %b/%h want 1/22", router_write_o, router_data_o);
        end
    endtask

    task automatic test_enable_drop();
        int  pulses = 0;
        logic [15:0] steps;
        wait_start();
        enable = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) steps = step_count_o;
            if (start_o !== 4'b0) pulses++;
            if (k == 5) begin
                router_full_i = 1'b1;
                spike_valid_i[2] = 1'b1;
                spike_packet_i[2*PW +: PW] = 32'h33;
                #1;
                n_checks++; if (spike_ack_o !== 4'b0100) begin n_fail++; $display("FAIL en_ack: got %b want 0100", spike_ack_o); end
            end
            if (k == 6) spike_valid_i[2] = 1'b0;
            if (k == SP - 1) begin
                n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL en_busy_last: got %b want 1", busy_o); end
            end
            if (k == SP) begin
                n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL en_idle: got %b want 0", busy_o); end
            end
            if (k == 35) begin
                router_full_i = 1'b0;
                #1;
                n_checks++; if (router_write_o !== 1'b1 || router_data_o !== 32'h33) begin
                    n_fail++; $display("FAIL en_idle_write: got %b/%h want 1/33", router_write_o, router_data_o);
                end
            end
            if (k == 36) begin
                n_checks++; if (router_write_o !== 1'b0) begin n_fail++; $display("FAIL en_idle_nodup: got %b want 0", router_write_o); end
            end
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL en_nopulse: got %0d pulses want 0", pulses); end
        n_checks++; if (step_count_o !== steps) begin n_fail++; $display("FAIL en_stepcnt: got %0d want %0d", step_count_o, steps); end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        wait_start();
        tick(); tick(); tick();
        router_full_i = 1'b1;
        spike_valid_i[0] = 1'b1;
        spike_packet_i[0*PW +: PW] = 32'h44;
        tick();
        spike_valid_i[0] = 1'b0;
        #1;
        n_checks++; if (router_data_o !== 32'h44) begin n_fail++; $display("FAIL rmid_buffered: got %h want 44", router_data_o); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (busy_o !== 1'b0 || start_o !== 4'b0 || spike_ack_o !== 4'b0) begin
            n_fail++; $display("FAIL rmid_ctrl: got busy=%b start=%b ack=%b want 0", busy_o, start_o, spike_ack_o);
        end
        n_checks++; if (router_data_o !== 32'h0) begin n_fail++; $display("FAIL rmid_data: got %h want 0", router_data_o); end
        n_checks++; if (step_count_o !== 16'h0 || overrun_count_o !== 8'h0) begin
            n_fail++; $display("FAIL rmid_counts: got %0d/%0d want 0/0", step_count_o, overrun_count_o);
        end
        enable = 1'b0;
        router_full_i = 1'b0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (router_write_o !== 1'b0) begin n_fail++; $display("FAIL rmid_discard%0d: got %b want 0", c, router_write_o); end
        end
    endtask

    task automatic test_spike_count();
        int acks = 0;
        enable = 1'b1;
        wait_start();
        spike_valid_i[0] = 1'b1;
        spike_packet_i[0*PW +: PW] = 32'h60;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (acks == 7) spike_valid_i[0] = 1'b0;
            #1;
            if (spike_ack_o[0]) acks++;
        end
        n_checks++; if (acks !== 7) begin n_fail++; $display("FAIL sc_acks: got %0d want 7", acks); end
        n_checks++; if (step_count_o !== 16'd1) begin n_fail++; $display("FAIL sc_step1: got %0d want 1", step_count_o); end
`ifdef SCHED_SPIKE_COUNT_EN
        n_checks++; if (spike_count_o !== 16'd7) begin n_fail++; $display("FAIL sc_running: got %0d want 7", spike_count_o); end
`else
        n_checks++; if (spike_count_o !== 16'd0) begin n_fail++; $display("FAIL sc_tied: got %0d want 0", spike_count_o); end
`endif
        wait_start();
        tick();
        n_checks++; if (step_count_o !== 16'd2) begin n_fail++; $display("FAIL sc_step2: got %0d want 2", step_count_o); end
        n_checks++; if (spike_count_o !== 16'd0) begin n_fail++; $display("FAIL sc_cleared: got %0d want 0", spike_count_o); end
`ifdef SCHED_SPIKE_COUNT_EN
        n_checks++; if (last_step_spikes_o !== 16'd7) begin n_fail++; $display("FAIL sc_last: got %0d want 7", last_step_spikes_o); end
`else
        n_checks++; if (last_step_spikes_o !== 16'd0) begin n_fail++; $display("FAIL sc_last_tied: got %0d want 0", last_step_spikes_o); end
`endif
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_burst();
        test_backpressure();
        test_round_robin();
        test_drain();
        test_enable_drop();
        test_reset_mid();
        test_spike_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_step_scheduler.md
# neuron_step_scheduler

Timestep controller and local-port arbiter for a cluster of neurons sharing one router local input. It issues periodic one-cycle `start` pulses to every neuron and tracks completed steps. Between pulses it round-robin-merges the neurons' spike packets into a single registered write stream toward the router. It honours the router's `local_full` backpressure.

## Interface
- `NUM_NEURONS`, 4: number of requesters (2..16).
- `PACKET_W`, 32: spike packet width.
- `STEP_PERIOD`, 30: cycles from one `start` pulse to the next when nothing is pending (min 4).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `enable` in 1: run timesteps while high.
- `start_o` out NUM_NEURONS: one-cycle start pulse, all bits identical.
- `spike_valid_i` in NUM_NEURONS: requester holds a packet.
- `spike_packet_i` in NUM_NEURONS*PACKET_W: packet i at bits [i*PACKET_W +: PACKET_W].
- `spike_ack_o` out NUM_NEURONS: one-hot; packet consumed this cycle.
- `router_data_o` out PACKET_W: packet to router `local_in`.
- `router_write_o` out 1: write enable to router `write_en_local`.
- `router_full_i` in 1: router `local_full`.
- `busy_o` out 1: state != IDLE.
- `step_count_o` out 16: completed START pulses.
- `overrun_count_o` out 8: steps that entered DRAIN.

## Operation
- FSM states: IDLE, START, COLLECT, DRAIN.
- IDLE: `enable`=1 at an edge → START.
- START lasts one cycle.
  - Drives `start_o` all ones.
  - Clears the period counter to 0.
  - Increments `step_count_o`; it wraps from 0xFFFF to 0.
  - No grants are made.
  - Next state is COLLECT.
- COLLECT:
  - The period counter increments each cycle.
  - At counter == STEP_PERIOD-1, evaluate the end of the step:
    - any `spike_valid_i` still unacked after this cycle → DRAIN, and `overrun_count_o` increments, saturating at 255;
    - otherwise `enable` → START, else IDLE.
- DRAIN: arbitrate until no valid remains, then `enable` → START, else IDLE.
- Output stage is a one-entry register (`out_vld`, `out_data`).
  - `router_write_o = out_vld & ~router_full_i`.
  - `router_data_o = out_data`.
- Grant rules (COLLECT/DRAIN only):
  - A grant is allowed when `!out_vld | router_write_o`.
  - Round-robin search starts at pointer `rr`. The first valid requester i gets `spike_ack_o[i]`=1 and its packet loads into the output register.
  - After a grant, `rr = (i+1) mod NUM_NEURONS`.
- Requesters hold valid and packet stable until acked; an ack retires exactly one packet.

## Timing
- Reset values:
  - FSM=IDLE; `start_o`, `spike_ack_o`, `router_write_o`, `busy_o` = 0.
  - `router_data_o`, `step_count_o`, `overrun_count_o` = 0.
  - `rr`=0; `out_vld`=0.
- `enable` sampled high at edge k → `start_o` high during cycle k+1.
- START-to-START interval is exactly STEP_PERIOD cycles without DRAIN.
- `spike_ack_o` is combinational in the grant cycle t; the packet appears on `router_data_o` at t+1.
  - `router_write_o` rises at t+1 if `router_full_i`=0.
  - If full, the packet is held and written on the first cycle full is low.
- Sustained throughput is one packet per cycle with full low.
- Full held high: at most one packet is buffered; no further acks occur.
- A valid arriving during a START cycle waits; it is eligible from the next cycle.
- `enable` dropping mid-step: the current step completes (including DRAIN), then IDLE.
- A buffered packet in the output stage survives the return to IDLE and is still written when full is low.
- `reset` mid-operation: all outputs go to reset values immediately; any buffered packet is discarded.

## Configuration
- `SCHED_SPIKE_COUNT_EN` defined:
  - adds outputs `spike_count_o` [15:0] and `last_step_spikes_o` [15:0];
  - `spike_count_o` increments per ack (saturating) and clears in START;
  - in START, `last_step_spikes_o` captures the finished step's count.
- Undefined: the counters are not built and both ports are tied to 0.

## Test plan
- Reset then `enable`=1, no spikes, STEP_PERIOD=30 → `start_o` pulses at 30-cycle intervals; `step_count_o` increments 1,2,3; `router_write_o` stays 0.
- All 4 neurons assert valid in one cycle with packets 0xA0..0xA3, full=0 → acks in order 0,1,2,3 on consecutive cycles; router writes 0xA0..0xA3 on the following 4 cycles.
- Full high for 5 cycles while neuron 2 holds 0xBEEF → exactly one ack; data 0xBEEF is held; one write after full drops; no duplicate.
- Neuron 1 raises valid at counter == STEP_PERIOD-1 with full=1 → DRAIN; `overrun_count_o`=1; next START only after the packet is acked.
- `enable` low mid-step → no further `start_o`; `busy_o` falls at step end. Assert `reset` during COLLECT → all outputs 0 asynchronously.
- With `SCHED_SPIKE_COUNT_EN`: 7 acks in step n → `last_step_spikes_o`=7 after START of step n+1; `spike_count_o`=0.
